// File: rtl/output_pkg.sv
// Shared definitions for the output-stage sequencer and the output stage itself:
// array geometry, select widths, FSM state encoding and the column mapping.
package output_pkg;

  localparam int N_COLS_ARRAY           = 16;
  localparam int NUMBER_MUX_OUT_1       = 4;
  localparam int NUMBER_INPUT_MUX_OUT_1 = (N_COLS_ARRAY + NUMBER_MUX_OUT_1 - 1) / NUMBER_MUX_OUT_1;
  localparam int SEL_WIDTH_MUX_OUT_1    = $clog2(1 + NUMBER_INPUT_MUX_OUT_1);
  localparam int SEL_WIDTH_MUX_OUT_2    = $clog2(NUMBER_MUX_OUT_1);
  localparam int BRAM_ADDR_WIDTH        = 15;
  localparam int CNT_WIDTH              = $clog2(N_COLS_ARRAY + 1);

  // Slot index width inside a group; kept at least one bit for degenerate groups.
  localparam int K_WIDTH = (NUMBER_INPUT_MUX_OUT_1 > 1) ? $clog2(NUMBER_INPUT_MUX_OUT_1) : 1;

  // Column index width: must hold G*NI-1 (ceil padding) and the count n itself.
  localparam int COL_WIDTH = $clog2(NUMBER_MUX_OUT_1 * NUMBER_INPUT_MUX_OUT_1 + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SEL,
    ST_CAP,
    ST_ACC,
    ST_WB,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Column c = g*NI + k for group g and slot k.
  function automatic logic [COL_WIDTH-1:0] col_of(
    input logic [SEL_WIDTH_MUX_OUT_2-1:0] g,
    input logic [K_WIDTH-1:0]             k
  );
    return COL_WIDTH'(g) * COL_WIDTH'(NUMBER_INPUT_MUX_OUT_1) + COL_WIDTH'(k);
  endfunction

endpackage

// File: rtl/output_addr_gen.sv
// Window address generator: latches base and column count on accept, runs the
// sequential column counter for CLEAR/DRAIN, and turns either that counter or
// an externally supplied column into a wrapped BRAM address plus validity.
module output_addr_gen
  import output_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       load_i,
  input  logic [BRAM_ADDR_WIDTH-1:0] base_i,
  input  logic [CNT_WIDTH-1:0]       n_i,
  input  logic                       cnt_inc_i,
  input  logic                       ext_sel_i,
  input  logic [COL_WIDTH-1:0]       ext_col_i,
  output logic [BRAM_ADDR_WIDTH-1:0] addr_o,
  output logic                       valid_o,
  output logic                       last_o
);

  logic [BRAM_ADDR_WIDTH-1:0] base_q;
  logic [COL_WIDTH-1:0]       n_q;
  logic [COL_WIDTH-1:0]       cnt_q;
  logic [COL_WIDTH-1:0]       col;

  // Capture the window on accept; step the sequential column counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      base_q <= '0;
      n_q    <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      base_q <= base_i;
      n_q    <= COL_WIDTH'(n_i);
      cnt_q  <= '0;
    end else if (cnt_inc_i) begin
      cnt_q  <= cnt_q + COL_WIDTH'(1);
    end
  end

  // Select the column source; the address add wraps naturally at the BRAM width.
  always_comb begin
    col     = ext_sel_i ? ext_col_i : cnt_q;
    addr_o  = base_q + BRAM_ADDR_WIDTH'(col);
    valid_o = (col < n_q);
    last_o  = ((cnt_q + COL_WIDTH'(1)) >= n_q);
  end

endmodule

// File: rtl/output_block_ctrl.sv
// Output-stage sequencer: optional window clear through BRAM port B, per-slot
// column walk through the mux tree with a read-modify-write per group (port B
// read, port A write one cycle later), and a drain that streams the window out
// through port A.
module output_block_ctrl
  import output_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           clear_i,
  input  logic                           drain_i,
  input  logic [CNT_WIDTH-1:0]           n_cols_i,
  input  logic [BRAM_ADDR_WIDTH-1:0]     base_addr_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           out_valid_o,
  output logic [SEL_WIDTH_MUX_OUT_1-1:0] sel_mux_out_1_o,
  output logic [SEL_WIDTH_MUX_OUT_2-1:0] sel_mux_out_2_o,
  output logic                           sel_mux_ld_o,
  output logic                           reg_wr_en_o,
  output logic                           reg_rst_o,
  output logic                           sel_mux_rst_o,
  output logic                           bram_rst_o,
  output logic                           bram_wr_en_a_o,
  output logic                           bram_wr_en_b_o,
  output logic [BRAM_ADDR_WIDTH-1:0]     bram_addr_a_o,
  output logic [BRAM_ADDR_WIDTH-1:0]     bram_addr_b_o
);

  localparam logic [SEL_WIDTH_MUX_OUT_2-1:0] G_LAST = SEL_WIDTH_MUX_OUT_2'(NUMBER_MUX_OUT_1 - 1);
  localparam logic [K_WIDTH-1:0]             K_LAST = K_WIDTH'(NUMBER_INPUT_MUX_OUT_1 - 1);

  state_e                         state_q, state_d;
  logic [K_WIDTH-1:0]             k_q;
  logic [SEL_WIDTH_MUX_OUT_2-1:0] g_q;
  logic                           wr_valid_q;
  logic [BRAM_ADDR_WIDTH-1:0]     wr_addr_q;
  logic                           out_valid_q;
  logic                           reg_rst_q;
  logic                           sel_mux_rst_q;

  logic                           accept;
  logic [SEL_WIDTH_MUX_OUT_1-1:0] sel1;
  logic [BRAM_ADDR_WIDTH-1:0]     gen_addr;
  logic                           gen_valid;
  logic                           gen_last;

  assign accept = (state_q == ST_IDLE) && (start_i || drain_i);
  // Level-1 select 0 is the zero input, so slot k maps to k+1 (widen before adding).
  assign sel1   = SEL_WIDTH_MUX_OUT_1'(k_q) + SEL_WIDTH_MUX_OUT_1'(1);

  output_addr_gen u_addr_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (accept),
    .base_i    (base_addr_i),
    .n_i       (n_cols_i),
    .cnt_inc_i ((state_q == ST_CLEAR) || (state_q == ST_DRAIN)),
    .ext_sel_i (state_q == ST_ACC),
    .ext_col_i (col_of(g_q, k_q)),
    .addr_o    (gen_addr),
    .valid_o   (gen_valid),
    .last_o    (gen_last)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Slot (k) and group (g) counters for the accumulate walk.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q <= '0;
      g_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          k_q <= '0;
          g_q <= '0;
        end
        ST_CAP:  g_q <= '0;
        ST_ACC:  g_q <= g_q + SEL_WIDTH_MUX_OUT_2'(1);
        ST_WB:   k_q <= k_q + K_WIDTH'(1);
        default: ;
      endcase
    end
  end

  // Write stage one cycle behind the port-B read issue, plus drain-data valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_valid_q  <= (state_q == ST_ACC) && gen_valid;
      wr_addr_q   <= gen_addr;
      out_valid_q <= (state_q == ST_DRAIN) && gen_valid;
    end
  end

  // Output-stage resets held by reset and released on the first edge after it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_rst_q     <= 1'b1;
      sel_mux_rst_q <= 1'b1;
    end else begin
      reg_rst_q     <= 1'b0;
      sel_mux_rst_q <= 1'b0;
    end
  end

  // Next-state and per-state output-stage controls.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path infers a latch.
    state_d         = state_q;
    sel_mux_out_1_o = '0;
    sel_mux_out_2_o = '0;
    sel_mux_ld_o    = 1'b0;
    reg_wr_en_o     = 1'b0;
    bram_wr_en_a_o  = 1'b0;
    bram_wr_en_b_o  = 1'b0;
    bram_addr_a_o   = '0;
    bram_addr_b_o   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i)      state_d = clear_i ? ST_CLEAR : ST_SEL;
        else if (drain_i) state_d = ST_DRAIN;
      end
      ST_CLEAR: begin
        bram_wr_en_b_o = 1'b1;
        bram_addr_b_o  = gen_addr;
        if (gen_last) state_d = ST_SEL;
      end
      ST_SEL: begin
        sel_mux_ld_o    = 1'b1;
        sel_mux_out_1_o = sel1;
        state_d         = ST_CAP;
      end
      ST_CAP: begin
        reg_wr_en_o     = 1'b1;
        sel_mux_out_1_o = sel1;
        state_d         = ST_ACC;
      end
      ST_ACC: begin
        sel_mux_ld_o    = 1'b1;
        sel_mux_out_1_o = sel1;
        sel_mux_out_2_o = g_q;
        bram_addr_b_o   = gen_addr;
        bram_wr_en_a_o  = wr_valid_q;
        bram_addr_a_o   = wr_addr_q;
        if (g_q == G_LAST) state_d = ST_WB;
      end
      ST_WB: begin
        bram_wr_en_a_o = wr_valid_q;
        bram_addr_a_o  = wr_addr_q;
        state_d        = (k_q == K_LAST) ? ST_DONE : ST_SEL;
      end
      ST_DRAIN: begin
        bram_addr_a_o = gen_addr;
        if (!gen_valid) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);
  assign out_valid_o   = out_valid_q;
  assign reg_rst_o     = reg_rst_q;
  assign sel_mux_rst_o = sel_mux_rst_q;
  assign bram_rst_o    = 1'b0;

endmodule

// File: tb/tb_output_block_ctrl.sv
// Directed bench for output_block_ctrl with a behavioural output stage:
// registered mux tree output, zero-writing port B, accumulating port A.
module tb_output_block_ctrl;
  import output_pkg::*;

  localparam int DW      = 16;
  localparam int DEPTH   = 2 ** BRAM_ADDR_WIDTH;
  localparam int MAX_LAT = 300;

  logic                           clk_i       = 1'b0;
  logic                           rst_i       = 1'b1;
  logic                           start_i     = 1'b0;
  logic                           clear_i     = 1'b0;
  logic                           drain_i     = 1'b0;
  logic [CNT_WIDTH-1:0]           n_cols_i    = '0;
  logic [BRAM_ADDR_WIDTH-1:0]     base_addr_i = '0;
  logic                           busy_o, done_o, out_valid_o;
  logic [SEL_WIDTH_MUX_OUT_1-1:0] sel_mux_out_1_o;
  logic [SEL_WIDTH_MUX_OUT_2-1:0] sel_mux_out_2_o;
  logic                           sel_mux_ld_o, reg_wr_en_o, reg_rst_o, sel_mux_rst_o, bram_rst_o;
  logic                           bram_wr_en_a_o, bram_wr_en_b_o;
  logic [BRAM_ADDR_WIDTH-1:0]     bram_addr_a_o, bram_addr_b_o;

  always #5 clk_i = ~clk_i;

  output_block_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .clear_i         (clear_i),
    .drain_i         (drain_i),
    .n_cols_i        (n_cols_i),
    .base_addr_i     (base_addr_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .out_valid_o     (out_valid_o),
    .sel_mux_out_1_o (sel_mux_out_1_o),
    .sel_mux_out_2_o (sel_mux_out_2_o),
    .sel_mux_ld_o    (sel_mux_ld_o),
    .reg_wr_en_o     (reg_wr_en_o),
    .reg_rst_o       (reg_rst_o),
    .sel_mux_rst_o   (sel_mux_rst_o),
    .bram_rst_o      (bram_rst_o),
    .bram_wr_en_a_o  (bram_wr_en_a_o),
    .bram_wr_en_b_o  (bram_wr_en_b_o),
    .bram_addr_a_o   (bram_addr_a_o),
    .bram_addr_b_o   (bram_addr_b_o)
  );

  // Array column values and expected drain data, set by the stimulus.
  logic [DW-1:0] col_val [N_COLS_ARRAY];
  logic [DW-1:0] exp_val [N_COLS_ARRAY];

  // Output stage model state.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] out2_q, rd_a_q, rd_b_q;
  int            wr_a_cnt = 0;
  int            wr_b_cnt = 0;

  int total = 0;
  int bad   = 0;

  function automatic logic [DW-1:0] stage_out(
    input logic [SEL_WIDTH_MUX_OUT_1-1:0] s1,
    input logic [SEL_WIDTH_MUX_OUT_2-1:0] s2
  );
    int idx;
    if (s1 == '0) return '0;
    idx = int'(s2) * NUMBER_INPUT_MUX_OUT_1 + int'(s1) - 1;
    return (idx < N_COLS_ARRAY) ? col_val[idx] : '0;
  endfunction

  // Output stage: registered mux output, one-cycle BRAM reads on both ports.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0007;
    out2_q = '0;
    rd_a_q = '0;
    rd_b_q = '0;
    forever begin
      @(posedge clk_i);
      if (bram_wr_en_a_o) begin
        mem[bram_addr_a_o] <= out2_q + rd_b_q;
        wr_a_cnt++;
      end
      if (bram_wr_en_b_o) begin
        mem[bram_addr_b_o] <= '0;
        wr_b_cnt++;
      end
      rd_a_q <= mem[bram_addr_a_o];
      rd_b_q <= mem[bram_addr_b_o];
      if (sel_mux_ld_o) out2_q <= stage_out(sel_mux_out_1_o, sel_mux_out_2_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One-cycle command pulse; returns just after the accept edge.
  task automatic issue(input logic st, input logic cl, input logic dr, input int n, input int base);
    @(negedge clk_i);
    start_i     = st;
    clear_i     = cl;
    drain_i     = dr;
    n_cols_i    = CNT_WIDTH'(n);
    base_addr_i = BRAM_ADDR_WIDTH'(base);
    @(negedge clk_i);
    start_i = 1'b0;
    clear_i = 1'b0;
    drain_i = 1'b0;
  endtask

  // Wait for done_o counting edges from the accept edge (edge 1); collect drain data.
  task automatic wait_done(input string tag, input int lat0, input int exp_lat, input int n_drain);
    int lat   = lat0;
    int nv    = 0;
    int first = 0;
    int last  = 0;
    logic [DW-1:0] e;
    while (!done_o && lat < MAX_LAT) begin
      @(negedge clk_i);
      lat++;
      if (out_valid_o) begin
        e = (nv < N_COLS_ARRAY) ? exp_val[nv] : '0;
        check($sformatf("%s data[%0d]", tag, nv), 32'(rd_a_q), 32'(e));
        if (nv == 0) first = lat;
        last = lat;
        nv++;
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " valid count"}, nv, n_drain);
    if (n_drain > 0) check({tag, " valid run"}, last - first + 1, n_drain);
    @(negedge clk_i);
    check({tag, " done pulse"}, 32'(done_o), 0);
    check({tag, " idle after"}, 32'(busy_o), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, b0, cyc;

    // Reset state.
    @(negedge clk_i);
    check("rst reg_rst", 32'(reg_rst_o), 1);
    check("rst sel_mux_rst", 32'(sel_mux_rst_o), 1);
    check("rst busy", 32'(busy_o), 0);
    check("rst enables", {reg_wr_en_o, sel_mux_ld_o, bram_wr_en_a_o, bram_wr_en_b_o, bram_rst_o}, 0);
    check("rst done/valid", {done_o, out_valid_o}, 0);
    rst_i = 1'b0;
    #1;
    check("rst held until edge", {reg_rst_o, sel_mux_rst_o}, 2'b11);
    @(negedge clk_i);
    check("rst released", {reg_rst_o, sel_mux_rst_o}, 2'b00);
    check("idle busy", 32'(busy_o), 0);

    // Clear + accumulate, all columns 5: DONE is the 45th edge counting the accept edge.
    for (int c = 0; c < N_COLS_ARRAY; c++) col_val[c] = 16'd5;
    a0 = wr_a_cnt; b0 = wr_b_cnt;
    issue(1'b1, 1'b1, 1'b0, 16, 'h100);
    wait_done("clr5", 1, 45, 0);
    check("clr5 port-B writes", wr_b_cnt - b0, 16);
    check("clr5 port-A writes", wr_a_cnt - a0, 16);
    for (int c = 0; c < 16; c++) check($sformatf("clr5 mem[%0h]", 'h100 + c), 32'(mem['h100 + c]), 5);
    check("clr5 below window", 32'(mem['h0FF]), 7);
    check("clr5 above window", 32'(mem['h110]), 7);

    // Two passes with column c = c, then drain expects 2c.
    for (int c = 0; c < N_COLS_ARRAY; c++) col_val[c] = DW'(c);
    issue(1'b1, 1'b1, 1'b0, 16, 'h100);
    wait_done("pass1", 1, 45, 0);
    issue(1'b1, 1'b0, 1'b0, 16, 'h100);
    wait_done("pass2", 1, 29, 0);
    for (int c = 0; c < N_COLS_ARRAY; c++) exp_val[c] = DW'(2 * c);
    issue(1'b0, 1'b0, 1'b1, 16, 'h100);
    wait_done("drain2c", 1, 18, 16);

    // n = 10: columns 10..15 untouched.
    a0 = wr_a_cnt;
    issue(1'b1, 1'b0, 1'b0, 10, 'h100);
    wait_done("n10", 1, 29, 0);
    check("n10 port-A writes", wr_a_cnt - a0, 10);
    for (int c = 0; c < N_COLS_ARRAY; c++) exp_val[c] = (c < 10) ? DW'(3 * c) : DW'(2 * c);
    issue(1'b0, 1'b0, 1'b1, 16, 'h100);
    wait_done("drain_n10", 1, 18, 16);

    // Address wrap at the top of the BRAM.
    for (int c = 0; c < N_COLS_ARRAY; c++) col_val[c] = DW'(c + 1);
    a0 = wr_a_cnt; b0 = wr_b_cnt;
    issue(1'b1, 1'b1, 1'b0, 4, 'h7FFE);
    wait_done("wrap", 1, 33, 0);
    check("wrap port-B writes", wr_b_cnt - b0, 4);
    check("wrap port-A writes", wr_a_cnt - a0, 4);
    check("wrap mem[7ffe]", 32'(mem['h7FFE]), 1);
    check("wrap mem[7fff]", 32'(mem['h7FFF]), 2);
    check("wrap mem[0000]", 32'(mem['h0000]), 3);
    check("wrap mem[0001]", 32'(mem['h0001]), 4);
    check("wrap mem[0002]", 32'(mem['h0002]), 7);
    check("wrap mem[7ffd]", 32'(mem['h7FFD]), 7);

    // Commands while busy are ignored and not queued.
    a0 = wr_a_cnt; b0 = wr_b_cnt;
    issue(1'b1, 1'b0, 1'b0, 16, 'h200);
    repeat (3) @(negedge clk_i);
    start_i = 1'b1; clear_i = 1'b1; drain_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; clear_i = 1'b0; drain_i = 1'b0;
    wait_done("busy_ignore", 5, 29, 0);
    check("busy_ignore no clear", wr_b_cnt - b0, 0);
    check("busy_ignore port-A writes", wr_a_cnt - a0, 16);
    @(negedge clk_i);
    check("busy_ignore not queued", 32'(busy_o), 0);

    // Asynchronous reset in the middle of ACC.
    issue(1'b1, 1'b0, 1'b0, 16, 'h300);
    cyc = 0;
    while (!bram_wr_en_a_o && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    check("midrst reached ACC write", 32'(bram_wr_en_a_o), 1);
    rst_i = 1'b1;
    #1;
    check("midrst write enables", {bram_wr_en_a_o, bram_wr_en_b_o}, 0);
    check("midrst busy", 32'(busy_o), 0);
    check("midrst mux load", 32'(sel_mux_ld_o), 0);
    check("midrst stage resets", {reg_rst_o, sel_mux_rst_o}, 2'b11);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst idle after release", 32'(busy_o), 0);
    check("midrst stage resets released", {reg_rst_o, sel_mux_rst_o}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
